cpu5_datapath_mc: RTL

- Parameterised multi-cycle successor to the single-cycle cpu5 datapath.
- Integrates datapath, internal decode and a sequencing FSM, so one instruction takes 3–5 states.
- One shared instruction/data memory port with a req/ack handshake, so memory may insert wait states.
- Sits between the cpu5 core top and the unified memory/bus wrapper.

---
 rtl/cpu5_datapath_mc.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cpu5_datapath_mc.sv
// cpu5_datapath_mc: multi-cycle RV-subset datapath with a shared req/ack memory port
module cpu5_datapath_mc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [31:0]     o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [31:0]     i_mem_rdata,
  output logic [XLEN-1:0] o_pc,
  output logic            o_retire,
  output logic            o_halt,
  output logic [2:0]      o_state
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_aluout, r_mdr, r_target;
  logic [31:0]     r_ir;
  logic            r_retire, r_halt;
  logic [XLEN-1:0] r_rf [32];

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic            w_is_lui, w_is_jal, w_is_br, w_is_lw, w_is_sw, w_is_addi, w_is_alu, w_legal;
  logic            w_taken;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [XLEN-1:0] w_slt, w_alu, w_pc4, w_ld_ext;

  assign w_op  = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));

  assign w_is_lui  = w_op == 7'b0110111;
  assign w_is_jal  = w_op == 7'b1101111;
  assign w_is_br   = w_op == 7'b1100011 && w_f3[2:1] == 2'b00;
  assign w_is_lw   = w_op == 7'b0000011 && w_f3 == 3'b010;
  assign w_is_sw   = w_op == 7'b0100011 && w_f3 == 3'b010;
  assign w_is_addi = w_op == 7'b0010011 && w_f3 == 3'b000;
  assign w_is_alu  = w_op == 7'b0110011 &&
                     ((w_f7 == 7'b0000000 && (w_f3 == 3'b000 || w_f3 == 3'b111 || w_f3 == 3'b110 ||
                                              w_f3 == 3'b100 || w_f3 == 3'b010)) ||
                      (w_f7 == 7'b0100000 && w_f3 == 3'b000));
  assign w_legal   = w_is_lui | w_is_jal | w_is_br | w_is_lw | w_is_sw | w_is_addi | w_is_alu;

  // BEQ has funct3[0]=0, BNE has funct3[0]=1, so equality xor that bit gives taken
  assign w_taken  = (r_a == r_b) != w_f3[0];
  assign w_pc4    = r_pc + XLEN'(4);
  assign w_ld_ext = XLEN'($signed(i_mem_rdata));
  assign w_slt    = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(r_b)};

  assign w_alu = w_is_lui              ? w_imm_u :
                 w_is_addi | w_is_lw   ? r_a + w_imm_i :
                 w_is_sw               ? r_a + w_imm_s :
                 w_f3 == 3'b111        ? r_a & r_b :
                 w_f3 == 3'b110        ? r_a | r_b :
                 w_f3 == 3'b100        ? r_a ^ r_b :
                 w_f3 == 3'b010        ? w_slt :
                 w_f7[5]               ? r_a - r_b : r_a + r_b;

  // Request is gated by reset so it drops the moment reset asserts, even mid-transaction
  assign o_mem_req   = i_rst_n & (r_state == S_FETCH || r_state == S_MEM);
  assign o_mem_we    = r_state == S_MEM && w_is_sw;
  assign o_mem_addr  = r_state == S_MEM ? {r_aluout[XLEN-1:2], 2'b00} : {r_pc[XLEN-1:2], 2'b00};
  assign o_mem_wdata = r_b[31:0];
  assign o_pc        = r_pc;
  assign o_retire    = r_retire;
  assign o_halt      = r_halt;
  assign o_state     = r_state;

  // Sequencer: fetch/decode/exec/mem/wb control, PC and pipeline-style holding registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_target <= '0;
      r_retire <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH:
          if (i_mem_ack) begin
            r_ir    <= i_mem_rdata;
            r_state <= S_DECODE;
          end
        S_DECODE: begin
          r_a      <= r_rf[w_rs1];
          r_b      <= r_rf[w_rs2];
          r_target <= r_pc + (w_is_jal ? w_imm_j : w_imm_b);
          if (!w_legal) begin
            r_halt  <= 1'b1;
            r_state <= S_TRAP;
          end else
            r_state <= S_EXEC;
        end
        S_EXEC:
          if (w_is_br) begin
            r_pc     <= w_taken ? r_target : w_pc4;
            r_retire <= 1'b1;
            r_state  <= S_FETCH;
          end else if (w_is_jal) begin
            r_aluout <= w_pc4;
            r_pc     <= r_target;
            r_state  <= S_WB;
          end else if (w_is_lw | w_is_sw) begin
            r_aluout <= w_alu;
            r_state  <= S_MEM;
          end else begin
            r_aluout <= w_alu;
            r_pc     <= w_pc4;
            r_state  <= S_WB;
          end
        S_MEM:
          if (i_mem_ack) begin
            if (w_is_sw) begin
              r_pc     <= w_pc4;
              r_retire <= 1'b1;
              r_state  <= S_FETCH;
            end else begin
              r_mdr   <= w_ld_ext;
              r_state <= S_WB;
            end
          end
        S_WB: begin
          if (w_is_lw) r_pc <= w_pc4;
          r_retire <= 1'b1;
          r_state  <= S_FETCH;
        end
        S_TRAP: r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end

  // Register file write-back; x0 is never written so it always reads zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (r_state == S_WB && w_rd != 5'd0)
      r_rf[w_rd] <= w_is_lw ? r_mdr : r_aluout;
endmodule
